// File: rtl/axis_deframer.sv
// Byte-stream deframer: strips START/STOP/ESCAPE framing from an AXI-Stream byte
// stream and emits payload bytes with tlast marking the final byte of each frame.
module axis_deframer #(
   parameter logic [7:0] START_BYTE  = 8'h7D,
   parameter logic [7:0] STOP_BYTE   = 8'h7E,
   parameter logic [7:0] ESCAPE_BYTE = 8'h7F,
   parameter logic [7:0] XOR_MASK    = 8'h00
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       target_tvalid,
   output logic       target_tready,
   input  logic [7:0] target_tdata,
   input  logic       target_tlast,
   output logic       initiator_tvalid,
   input  logic       initiator_tready,
   output logic [7:0] initiator_tdata,
   output logic       initiator_tlast,
   output logic       frame_error,
   output logic       in_frame
);

   // state    | meaning
   // IDLE     | outside a frame, bytes other than START are dropped
   // IN_FRAME | collecting payload, watching for ESCAPE/STOP/START
   // ESCAPED  | next byte is literal payload (XOR_MASK applied)
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      ESCAPED  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       hold_valid_q, hold_valid_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_last_q, out_last_d;
   logic       frame_error_q, frame_error_d;

   logic       accept;
   logic       is_payload;
   logic       is_close;
   logic [7:0] payload_byte;

   // Framing is in-band only, so the incoming tlast carries no meaning here.
   logic       unused_tlast;
   assign unused_tlast = target_tlast;

   assign target_tready = !out_valid_q || initiator_tready;
   assign accept        = target_tvalid && target_tready;

   always_comb begin
      state_d       = state_q;
      hold_valid_d  = hold_valid_q;
      hold_data_d   = hold_data_q;
      out_valid_d   = out_valid_q && !initiator_tready;
      out_data_d    = out_data_q;
      out_last_d    = out_last_q;
      frame_error_d = 1'b0;
      is_payload    = 1'b0;
      is_close      = 1'b0;
      payload_byte  = target_tdata;

      if (accept) begin
         case (state_q)
            IDLE: begin
               if (target_tdata == START_BYTE) state_d = IN_FRAME;
            end
            IN_FRAME: begin
               if (target_tdata == ESCAPE_BYTE) begin
                  state_d = ESCAPED;
               end else if (target_tdata == STOP_BYTE) begin
                  is_close = 1'b1;
                  state_d  = IDLE;
               end else if (target_tdata == START_BYTE) begin
                  // Unexpected START: close the open frame and begin a new one.
                  is_close      = 1'b1;
                  frame_error_d = 1'b1;
               end else begin
                  is_payload = 1'b1;
               end
            end
            ESCAPED: begin
               is_payload   = 1'b1;
               payload_byte = target_tdata ^ XOR_MASK;
               state_d      = IN_FRAME;
            end
            default: state_d = IDLE;
         endcase
      end

      // The hold byte is released only once we know whether it ends the frame.
      if (is_payload) begin
         if (hold_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_last_d  = 1'b0;
         end
         hold_valid_d = 1'b1;
         hold_data_d  = payload_byte;
      end

      if (is_close && hold_valid_q) begin
         out_valid_d  = 1'b1;
         out_data_d   = hold_data_q;
         out_last_d   = 1'b1;
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         hold_valid_q  <= 1'b0;
         hold_data_q   <= 8'h00;
         out_valid_q   <= 1'b0;
         out_data_q    <= 8'h00;
         out_last_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_valid_q  <= hold_valid_d;
         hold_data_q   <= hold_data_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_last_q    <= out_last_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign initiator_tvalid = out_valid_q;
   assign initiator_tdata  = out_data_q;
   assign initiator_tlast  = out_last_q;
   assign frame_error      = frame_error_q;
   assign in_frame         = (state_q != IDLE);

endmodule

// File: tb/tb_axis_deframer.sv
// Scoreboard bench for axis_deframer: two instances (XOR_MASK 00 and 20) share one
// input stream; expected output bytes are queued per instance and popped by monitors.
module tb_axis_deframer;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       target_tvalid = 1'b0;
   logic [7:0] target_tdata = 8'h00;
   logic       target_tlast = 1'b0;
   logic       initiator_tready = 1'b1;

   logic       t_rdy0, v0, l0, fe0, if0;
   logic [7:0] d0;
   logic       t_rdy1, v1, l1, fe1, if1;
   logic [7:0] d1;

   int         total = 0;
   int         bad = 0;
   int         fe_cnt = 0;
   int         inframe_acc = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] exp0, exp1;

   axis_deframer u_dut0 (
      .aclk(aclk), .aresetn(aresetn),
      .target_tvalid(target_tvalid), .target_tready(t_rdy0),
      .target_tdata(target_tdata), .target_tlast(target_tlast),
      .initiator_tvalid(v0), .initiator_tready(initiator_tready),
      .initiator_tdata(d0), .initiator_tlast(l0),
      .frame_error(fe0), .in_frame(if0)
   );

   axis_deframer #(.XOR_MASK(8'h20)) u_dut1 (
      .aclk(aclk), .aresetn(aresetn),
      .target_tvalid(target_tvalid), .target_tready(t_rdy1),
      .target_tdata(target_tdata), .target_tlast(target_tlast),
      .initiator_tvalid(v1), .initiator_tready(initiator_tready),
      .initiator_tdata(d1), .initiator_tlast(l1),
      .frame_error(fe1), .in_frame(if1)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push(input logic [7:0] e0, input logic [7:0] e1, input logic last);
      q0.push_back({last, e0});
      q1.push_back({last, e1});
   endtask

   // Monitors: pop one expectation per completed output handshake.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (fe0) fe_cnt++;
         if (v0 && initiator_tready) begin
            if (q0.size() == 0) begin
               total++; bad++;
               $display("FAIL out0_unexpected: got %0h last=%0b expected none", d0, l0);
            end else begin
               exp0 = q0.pop_front();
               check("out0", 32'({l0, d0}), 32'(exp0));
            end
         end
         if (v1 && initiator_tready) begin
            if (q1.size() == 0) begin
               total++; bad++;
               $display("FAIL out1_unexpected: got %0h last=%0b expected none", d1, l1);
            end else begin
               exp1 = q1.pop_front();
               check("out1", 32'({l1, d1}), 32'(exp1));
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int   n;
      logic ok;
      logic inf;
      n = 0; ok = 1'b0; inf = 1'b0;
      target_tvalid = 1'b1;
      target_tdata  = b;
      while (!ok && n < 200) begin
         @(negedge aclk);
         ok  = t_rdy0;
         inf = if0;
         @(posedge aclk);
         n++;
      end
      #1;
      target_tvalid = 1'b0;
      if (ok && inf) inframe_acc++;
      if (!ok) begin
         total++; bad++;
         $display("FAIL send_timeout: byte %0h not accepted, expected accept within 200 cycles", b);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || v0 || v1) && n < 100) begin
         @(posedge aclk);
         n++;
      end
      repeat (2) @(posedge aclk);
      #1;
      check(name, 32'(q0.size() + q1.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_tvalid", 32'(v0), 32'd0);
      check("rst_tlast", 32'(l0), 32'd0);
      check("rst_tdata", 32'(d0), 32'h00);
      check("rst_ferr", 32'(fe0), 32'd0);
      check("rst_inframe", 32'(if0), 32'd0);
      check("rst_tready", 32'(t_rdy0), 32'd1);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Basic frame, with output latency check
      fe_cnt = 0;
      push(8'h11, 8'h11, 1'b0);
      push(8'h22, 8'h22, 1'b1);
      send(8'h7D); send(8'h11); send(8'h22);
      check("latency_11", 32'({v0, d0, l0}), 32'({1'b1, 8'h11, 1'b0}));
      send(8'h7E);
      drain("drain_basic");
      check("ferr_basic", 32'(fe_cnt), 32'd0);

      // Escapes, with and without XOR mask; START inside frame closes it
      fe_cnt = 0;
      push(8'h7E, 8'h5E, 1'b0);
      push(8'h7F, 8'h5F, 1'b1);
      send(8'h7D); send(8'h7F); send(8'h7E); send(8'h7F); send(8'h7F); send(8'h7D);
      send(8'h7E);
      drain("drain_escape");
      check("ferr_escape", 32'(fe_cnt), 32'd1);
      check("idle_escape", 32'(if0), 32'd0);

      // Junk in IDLE dropped, then an empty frame
      fe_cnt = 0;
      inframe_acc = 0;
      send(8'hAA); send(8'h7F); send(8'h7D); send(8'h7E);
      drain("drain_empty");
      check("inframe_accepts", 32'(inframe_acc), 32'd1);
      check("ferr_empty", 32'(fe_cnt), 32'd0);

      // Mid-frame START
      fe_cnt = 0;
      push(8'h01, 8'h01, 1'b0);
      push(8'h02, 8'h02, 1'b1);
      push(8'h03, 8'h03, 1'b1);
      send(8'h7D); send(8'h01); send(8'h02); send(8'h7D);
      check("ferr_pulse_on", 32'(fe0), 32'd1);
      check("inframe_restart", 32'(if0), 32'd1);
      send(8'h03);
      check("ferr_pulse_off", 32'(fe0), 32'd0);
      send(8'h7E);
      drain("drain_restart");
      check("ferr_restart", 32'(fe_cnt), 32'd1);

      // Downstream stall
      push(8'h01, 8'h01, 1'b0);
      push(8'h02, 8'h02, 1'b0);
      push(8'h03, 8'h03, 1'b1);
      initiator_tready = 1'b0;
      send(8'h7D); send(8'h01); send(8'h02);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check("stall_tready", 32'(t_rdy0), 32'd0);
         check("stall_hold", 32'({v0, d0, l0}), 32'({1'b1, 8'h01, 1'b0}));
      end
      @(posedge aclk); #1;
      initiator_tready = 1'b1;
      send(8'h03); send(8'h7E);
      drain("drain_stall");

      // Reset mid-frame discards held and registered bytes
      initiator_tready = 1'b0;
      send(8'h7D); send(8'h01); send(8'h02);
      @(posedge aclk); #1;
      aresetn = 1'b0;
      #2;
      check("midrst_tvalid", 32'(v0), 32'd0);
      check("midrst_inframe", 32'(if0), 32'd0);
      check("midrst_tready", 32'(t_rdy0), 32'd1);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      initiator_tready = 1'b1;
      send(8'h7E);
      repeat (4) @(posedge aclk);
      #1;
      check("postrst_tvalid", 32'(v0), 32'd0);
      check("postrst_inframe", 32'(if0), 32'd0);
      push(8'h55, 8'h55, 1'b1);
      send(8'h7D); send(8'h55); send(8'h7E);
      drain("drain_postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_deframer.md
AXIS_DEFRAMER -- requirements
Module: axis_deframer

Interface
REQ-001 Parameter START_BYTE, default 8'h7D, byte value that opens a frame.
REQ-002 Parameter STOP_BYTE, default 8'h7E, byte value that closes a frame.
REQ-003 Parameter ESCAPE_BYTE, default 8'h7F, byte value that makes the following byte literal.
REQ-004 Parameter XOR_MASK, default 8'h00, value XORed onto each escaped byte; 8'h00 gives plain feed-through.
REQ-005 aclk  input  1  clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous, active-low.
REQ-007 target_tvalid  input  1  input byte valid.
REQ-008 target_tready  output  1  input byte accepted when high with target_tvalid.
REQ-009 target_tdata  input  8  input byte.
REQ-010 target_tlast  input  1  ignored; framing comes from in-band bytes only.
REQ-011 initiator_tvalid  output  1  output byte valid (registered).
REQ-012 initiator_tready  input  1  downstream ready.
REQ-013 initiator_tdata  output  8  decoded payload byte (registered).
REQ-014 initiator_tlast  output  1  last payload byte of a frame (registered).
REQ-015 frame_error  output  1  one-cycle pulse on a protocol error.
REQ-016 in_frame  output  1  high while the state is IN_FRAME or ESCAPED.

Function
REQ-017 The block SHALL have three states, IDLE, IN_FRAME and ESCAPED; state changes occur only on an accepted input byte (tvalid && tready).
REQ-018 In IDLE:
  - START_BYTE SHALL move the block to IN_FRAME.
  - All other bytes, ESCAPE_BYTE included, SHALL be dropped silently.
REQ-019 In IN_FRAME:
  - ESCAPE_BYTE SHALL move the block to ESCAPED and produce no data.
  - STOP_BYTE SHALL close the frame and move the block to IDLE.
  - START_BYTE SHALL be an error (REQ-024).
  - Any other byte SHALL be a payload byte.
REQ-020 In ESCAPED, any byte value SHALL be taken as payload byte (byte ^ XOR_MASK) and the block SHALL return to IN_FRAME; START_BYTE, STOP_BYTE and ESCAPE_BYTE values are literal here.
REQ-021 A one-byte hold register (hold_valid, hold_data) SHALL delay each payload byte until the next payload byte or frame end is known:
  - On a new payload byte with hold_valid=1, hold_data SHALL be pushed to the output with tlast=0.
  - The new byte SHALL then be loaded into hold.
REQ-022 On frame close, if hold_valid=1, hold_data SHALL be pushed with tlast=1 and hold_valid cleared. If hold_valid=0 (empty frame), nothing SHALL be output.
REQ-023 Output stage: a single register. target_tready SHALL equal (!initiator_tvalid || initiator_tready), combinationally.
  - Each accepted input byte pushes at most one output byte, so no overflow is possible.
  - initiator_tdata and initiator_tlast SHALL be stable while initiator_tvalid=1 and initiator_tready=0.
REQ-024 START_BYTE accepted in IN_FRAME SHALL:
  - pulse frame_error for one cycle;
  - close the current frame as in REQ-022;
  - leave the block in IN_FRAME, with a new frame started.
REQ-025 Latency: a payload byte SHALL appear on initiator_tvalid one cycle after the accept of the next payload byte or the frame-closing byte.
REQ-026 A push and an output drain in the same cycle SHALL load the output register with the new byte, with no bubble.
REQ-027 initiator_tdata SHALL be registered, never combinational from target_tdata.

Reset
REQ-028 While aresetn=0:
  - state SHALL be IDLE;
  - hold_valid, initiator_tvalid, initiator_tlast and frame_error SHALL be 0;
  - hold_data and initiator_tdata SHALL be 8'h00.
REQ-029 Reset mid-frame SHALL discard the held byte and the output register contents; nothing from that frame SHALL be emitted after reset is released.
REQ-030 target_tready SHALL be 1 while in reset, because the output register is empty.

Verification
REQ-031 Input 7D 11 22 7E, ready=1 -> output 11(last=0), 22(last=1); frame_error never high.
REQ-032 Input 7D 7F 7E 7F 7F 7D... with XOR_MASK=0 -> payload 7E then 7F. With XOR_MASK=20 -> payload 5E, 5F.
REQ-033 Input AA 7F 7D 7E -> no output (AA and 7F dropped in IDLE, then an empty frame); in_frame high for exactly one accepted byte.
REQ-034 Input 7D 01 02 7D 03 7E -> output 01, 02(last=1), 03(last=1); frame_error pulses once, on the accept of the second 7D.
REQ-035 Input 7D 01 02 03 7E with initiator_tready=0 for 5 cycles -> target_tready=0 after the first output is registered; the output holds 01 stable, then resumes 01, 02, 03(last) with no loss or duplication.
REQ-036 Input 7D 01 02, then aresetn pulsed low, then 7E -> no output at all; state IDLE after reset.
